frame_commit_fifo: RTL and testbench
====================================

# frame_commit_fifo

Frame-atomic instruction buffer between the 32-bit word aggregator and the instruction parser on the 50 MHz Ethernet clock domain. It holds every aggregated word of an incoming frame speculatively and releases the frame to the parser only after the frame check sequence result arrives. Words from frames that fail FCS, or that overflow the buffer, are discarded as a unit. The parser therefore never sees a partial or corrupted instruction stream.

## Interface

Parameters:
- DEPTH, 64: word capacity; must be a power of two, at least 4.
- WIDTH, 32: word width.

Ports:
- clk  in  1  system clock (50 MHz Ethernet clock). Single clock domain.
- rst  in  1  reset, asynchronous and active-high.
- axiiv  in  1  input word valid; one-cycle strobe per word from the aggregator. No backpressure.
- axiid  in  WIDTH  input word.
- commit  in  1  one-cycle pulse meaning the current frame passed FCS.
- discard  in  1  one-cycle pulse meaning the current frame failed FCS or was killed.
- axiov  out  1  output word valid.
- axiod  out  WIDTH  output word.
- axiir  in  1  downstream ready; a transfer occurs when axiov and axiir are both high.
- full  out  1  buffer holds DEPTH words, counting both committed and speculative words.
- overflow  out  1  sticky flag: at least one word has been lost. Cleared only by rst.
- frames_committed  out  16  count of frames released; wraps modulo 2^16.
- frames_dropped  out  16  count of frames discarded; wraps modulo 2^16.

## Operation

- State is held in three pointers, each $clog2(DEPTH)+1 bits wide and wrapping naturally:
  - wr_ptr: the speculative write point.
  - cm_ptr: the committed boundary.
  - rd_ptr: the read point.
- Memory is DEPTH×WIDTH, written at wr_ptr[low bits].
- full = (wr_ptr − rd_ptr == DEPTH).
- Write behaviour:
  - axiiv high, not full, frame not poisoned: store the word and increment wr_ptr.
  - axiiv high while full: drop the word, set overflow, set the internal poisoned bit for the current frame.
- Commit (commit high, discard low):
  - Not poisoned: cm_ptr ← wr_ptr, counting any word written in the same cycle. frames_committed increments.
  - Poisoned: behave exactly as a discard.
- Discard (discard high, or poisoned commit):
  - wr_ptr ← cm_ptr. Any word presented in the same cycle is also dropped.
  - frames_dropped increments and the poisoned bit clears.
- commit and discard high in the same cycle: discard wins.
- A commit or discard with no words written since the last boundary still updates the matching counter.
- Read side sees only words in [rd_ptr, cm_ptr). Speculative words are never visible downstream.
- Output stage:
  - A single output register. It loads when cm_ptr ≠ rd_ptr and the register is empty or transferring this cycle.
  - Each load increments rd_ptr.
  - Back-to-back transfers run at 1 word/cycle.
- axiov/axiod hold stable while axiov is high and axiir is low.
- Simultaneous write, commit and read in the same cycle are all legal and all take effect.
- Reset mid-frame: all pointers, the output register and the counters clear. Speculative and committed contents are lost.

## Timing

- Reset values: axiov=0, axiod=0, full=0, overflow=0, frames_committed=0, frames_dropped=0. Internal: pointers=0, poisoned=0.
- All outputs are registered; there are no combinational paths from input to output.
- Latency: a commit sampled at edge E makes its first word appear at edge E+1 (axiov high in cycle E+1), provided the output register was empty.
- Throughput: one word in per cycle and one word out per cycle sustained.
- full and overflow update on the edge that samples the causing write. full deasserts on the edge after the transfer or discard that frees space.
- Counters update on the edge that samples commit/discard.

## Test plan

- **Single frame:** write 3 words 0xA0000001..3, commit in the same cycle as the 3rd word, axiir=1.
  - Expect: axiov=1 the next cycle, words out in order on 3 consecutive cycles; frames_committed=1.
- **Discard:** write 5 words, pulse discard.
  - Expect: axiov never asserts; frames_dropped=1.
  - Then write 1 word and commit; only that word appears.
- **Backpressure:** commit 4 words with axiir=0 for 6 cycles, then axiir=1.
  - Expect: axiod holds word 0 stable throughout the stall; then 4 transfers in order.
- **Overflow, DEPTH=4:** write 6 words, then commit.
  - Expect: full=1 after the 4th word, overflow=1.
  - Frame is dropped: frames_dropped=1, frames_committed=0, no output, full=0 afterwards.
- **Simultaneous events:**
  - commit+discard in the same cycle: treated as a discard.
  - Write and read in the same cycle with 2 committed words buffered: occupancy counts and pointers stay consistent.
- **Async reset mid-frame:** after 2 committed words (output stalled) and 3 speculative words, assert rst between clock edges.
  - Expect: axiov=0 and counters=0 immediately.
  - After release, a new 1-word frame commits and passes through correctly.

Source files
------------

// File: rtl/frame_commit_fifo.sv
// frame_commit_fifo: frame-atomic word buffer that releases a frame only after its FCS verdict arrives.
module frame_commit_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [WIDTH-1:0] axiid,
  input  logic             commit,
  input  logic             discard,
  output logic             axiov,
  output logic [WIDTH-1:0] axiod,
  input  logic             axiir,
  output logic             full,
  output logic             overflow,
  output logic [15:0]      frames_committed,
  output logic [15:0]      frames_dropped
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, cm_ptr, rd_ptr, wr_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic poisoned, drop, wr_en, do_disc, do_commit, load;
  assign full = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
  always_comb begin
    drop      = axiiv && full;
    wr_en     = axiiv && !full && !poisoned;
    // a commit arriving with (or after) a lost word must not release a truncated frame
    do_disc   = discard || (commit && (poisoned || drop));
    do_commit = commit && !do_disc;
    wr_next   = wr_ptr + (AW+1)'(wr_en);
    load      = (cm_ptr != rd_ptr) && (!axiov || axiir);
  end
  always_ff @(posedge clk)
    if (wr_en && !do_disc) mem[wr_ptr[AW-1:0]] <= axiid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr           <= '0;
      cm_ptr           <= '0;
      rd_ptr           <= '0;
      poisoned         <= 1'b0;
      overflow         <= 1'b0;
      frames_committed <= '0;
      frames_dropped   <= '0;
      axiov            <= 1'b0;
      axiod            <= '0;
    end else begin
      wr_ptr           <= do_disc ? cm_ptr : wr_next;
      cm_ptr           <= do_commit ? wr_next : cm_ptr;
      rd_ptr           <= rd_ptr + (AW+1)'(load);
      poisoned         <= !do_disc && (poisoned || drop);
      overflow         <= overflow || drop;
      frames_committed <= frames_committed + 16'(do_commit);
      frames_dropped   <= frames_dropped + 16'(do_disc);
      axiov            <= load || (axiov && !axiir);
      axiod            <= load ? mem[rd_ptr[AW-1:0]] : axiod;
    end
endmodule

// File: tb/tb_frame_commit_fifo.sv
// tb_frame_commit_fifo: scoreboard bench; a 16-deep instance for data flow and a 4-deep one for overflow.
module tb_frame_commit_fifo;
  logic clk = 0, rst = 1, axiiv = 0, commit = 0, discard = 0, axiir = 0;
  logic [31:0] axiid = 0;
  logic axiov, full, overflow, s_axiov, s_full, s_overflow;
  logic [31:0] axiod, s_axiod;
  logic [15:0] fc, fd, s_fc, s_fd;
  int checks = 0, passed = 0, exp_c = 0, exp_d = 0;
  bit mon_en = 1;
  logic [31:0] exp_q[$], pend[$];

  always #5 clk = ~clk;

  frame_commit_fifo #(.DEPTH(16), .WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .commit(commit), .discard(discard),
    .axiov(axiov), .axiod(axiod), .axiir(axiir), .full(full), .overflow(overflow),
    .frames_committed(fc), .frames_dropped(fd));

  frame_commit_fifo #(.DEPTH(4), .WIDTH(32)) u_small (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .commit(commit), .discard(discard),
    .axiov(s_axiov), .axiod(s_axiod), .axiir(axiir), .full(s_full), .overflow(s_overflow),
    .frames_committed(s_fc), .frames_dropped(s_fd));

  // scoreboard: every transfer of the 16-deep instance must match the next committed word
  always @(negedge clk)
    if (mon_en && !rst && axiov && axiir) begin
      logic [31:0] w;
      checks++;
      if (exp_q.size() == 0) $display("FAIL out_unexpected got=%h expected=none", axiod);
      else begin
        w = exp_q.pop_front();
        if (axiod !== w) $display("FAIL out_word got=%h expected=%h", axiod, w);
        else passed++;
      end
    end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  task step();
    @(posedge clk); #1;
  endtask

  task send(input logic [31:0] w, input logic c, input logic d);
    axiiv = 1; axiid = w; commit = c; discard = d;
    pend.push_back(w);
    if (d) begin pend.delete(); exp_d++; end
    else if (c) begin foreach (pend[i]) exp_q.push_back(pend[i]); pend.delete(); exp_c++; end
    step();
    axiiv = 0; commit = 0; discard = 0;
  endtask

  task pulse(input logic c, input logic d);
    commit = c; discard = d;
    if (d) begin pend.delete(); exp_d++; end
    else if (c) begin foreach (pend[i]) exp_q.push_back(pend[i]); pend.delete(); exp_c++; end
    step();
    commit = 0; discard = 0;
  endtask

  task clear_model();
    exp_q.delete(); pend.delete(); exp_c = 0; exp_d = 0;
  endtask

  task test_reset();
    step();
    checks++;
    if ({axiov, axiod, full, overflow, fc, fd} !== '0)
      $display("FAIL reset_outputs got=%b/%h/%b/%b/%0d/%0d expected=all zero", axiov, axiod, full, overflow, fc, fd);
    else passed++;
    rst = 0;
    step();
  endtask

  task test_single_frame();
    axiir = 1;
    send(32'hA000_0001, 0, 0);
    send(32'hA000_0002, 0, 0);
    send(32'hA000_0003, 1, 0);
    checks++;
    if (axiov !== 1'b0) $display("FAIL single_pre got=%b expected=0", axiov); else passed++;
    step();
    checks++;
    if (axiov !== 1'b1) $display("FAIL single_latency got=%b expected=1", axiov); else passed++;
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) $display("FAIL single_throughput got=%0d left expected=0", exp_q.size()); else passed++;
    checks++;
    if (fc !== 16'(exp_c)) $display("FAIL single_fc got=%0d expected=%0d", fc, exp_c); else passed++;
  endtask

  task test_discard();
    for (int i = 0; i < 5; i++) send(32'hD000_0000 + i, 0, 0);
    pulse(0, 1);
    repeat (4) begin
      checks++;
      if (axiov !== 1'b0) $display("FAIL discard_hidden got=%b expected=0", axiov); else passed++;
      step();
    end
    checks++;
    if (fd !== 16'(exp_d)) $display("FAIL discard_fd got=%0d expected=%0d", fd, exp_d); else passed++;
    send(32'hD100_0001, 1, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0) $display("FAIL discard_drain got=%0d left expected=0", exp_q.size()); else passed++;
  endtask

  task test_backpressure();
    axiir = 0;
    for (int i = 0; i < 4; i++) send(32'hB000_0010 + i, i == 3, 0);
    repeat (6) begin
      step();
      checks++;
      if (axiov !== 1'b1 || axiod !== 32'hB000_0010)
        $display("FAIL stall_hold got=%b/%h expected=1/b0000010", axiov, axiod);
      else passed++;
    end
    axiir = 1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0 || axiov !== 1'b0)
      $display("FAIL stall_drain got=%0d left/%b expected=0/0", exp_q.size(), axiov);
    else passed++;
  endtask

  task test_simultaneous();
    send(32'hC000_0001, 0, 0);
    send(32'hC000_0002, 0, 0);
    send(32'hC000_0003, 1, 1);
    repeat (3) begin
      checks++;
      if (axiov !== 1'b0) $display("FAIL cd_hidden got=%b expected=0", axiov); else passed++;
      step();
    end
    checks++;
    if (fd !== 16'(exp_d) || fc !== 16'(exp_c))
      $display("FAIL cd_counts got=%0d/%0d expected=%0d/%0d", fc, fd, exp_c, exp_d);
    else passed++;
    axiir = 0;
    send(32'hE000_0001, 0, 0);
    send(32'hE000_0002, 1, 0);
    step();
    axiir = 1;
    for (int i = 0; i < 6; i++) begin
      send(32'hE100_0000 + i, i[0], 0);
      checks++;
      if (full !== 1'b0) $display("FAIL rw_full got=%b expected=0", full); else passed++;
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0 || fc !== 16'(exp_c))
      $display("FAIL rw_drain got=%0d left fc=%0d expected=0 fc=%0d", exp_q.size(), fc, exp_c);
    else passed++;
  endtask

  task test_overflow();
    mon_en = 0;
    rst = 1; #2; rst = 0;
    clear_model();
    axiir = 1;
    for (int i = 0; i < 6; i++) begin
      send(32'hF000_0000 + i, 0, 0);
      if (i == 3) begin
        checks++;
        if (s_full !== 1'b1 || s_overflow !== 1'b0)
          $display("FAIL ovf_full got=%b/%b expected=1/0", s_full, s_overflow);
        else passed++;
      end
    end
    checks++;
    if (s_overflow !== 1'b1) $display("FAIL ovf_flag got=%b expected=1", s_overflow); else passed++;
    pulse(1, 0);
    repeat (3) step();
    checks++;
    if (s_fd !== 16'd1 || s_fc !== 16'd0 || s_full !== 1'b0 || s_axiov !== 1'b0 || s_overflow !== 1'b1)
      $display("FAIL ovf_after got=fd%0d fc%0d full%b v%b o%b expected=fd1 fc0 full0 v0 o1",
               s_fd, s_fc, s_full, s_axiov, s_overflow);
    else passed++;
    rst = 1; #2; rst = 0;
    clear_model();
    mon_en = 1;
  endtask

  task test_async_reset();
    axiir = 0;
    send(32'h5000_0001, 0, 0);
    send(32'h5000_0002, 1, 0);
    for (int i = 0; i < 3; i++) send(32'h5100_0000 + i, 0, 0);
    #2 rst = 1;
    #1;
    checks++;
    if (axiov !== 1'b0 || fc !== 16'd0 || fd !== 16'd0 || full !== 1'b0)
      $display("FAIL async_rst got=%b/%0d/%0d/%b expected=0/0/0/0", axiov, fc, fd, full);
    else passed++;
    clear_model();
    #1 rst = 0;
    step();
    axiir = 1;
    send(32'h6000_0001, 1, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0 || fc !== 16'd1 || axiov !== 1'b0)
      $display("FAIL post_rst got=%0d left fc=%0d v=%b expected=0 fc=1 v=0", exp_q.size(), fc, axiov);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_discard();
    test_backpressure();
    test_simultaneous();
    test_overflow();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
